// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage registers.
package pipe_pkg;

  // Stage fill state. The encoding 2'b11 is never entered; if it ever shows
  // up (e.g. after an upset) the control logic steers it back to EMPTY.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } stage_state_t;

  // MIPS NOP (sll $0,$0,0); default contents for instruction-carrying stages.
  localparam logic [31:0] NOP_BUNDLE = 32'h0000_0000;

  // Number of entries held for a given fill state.
  function automatic logic [1:0] state_occupancy(input stage_state_t s);
    logic [1:0] occ;
    unique case (s)
      EMPTY:   occ = 2'd0;
      ONE:     occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/dffe_sclr.sv
// Enable register with synchronous clear to a parameterised value.
module dffe_sclr #(
  parameter int unsigned          WIDTH     = 32,
  parameter logic [WIDTH-1:0]     RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear wins over load; otherwise hold unless enabled.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values, independent of the order blocks are evaluated in.
    if (clr) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register: valid/ready on both sides, 2-entry skid buffer,
// synchronous flush. Both handshake outputs come straight from registered
// state, so there is no combinational path from out_ready to in_ready.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  stage_state_t     state_q, state_d;
  logic             in_fire, out_fire;
  logic             clr;
  logic             main_en, main_from_skid, skid_en;
  logic [WIDTH-1:0] main_d, skid_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Reset and flush have identical effect on state and data; reset simply
  // dominates in the sense that both collapse to the same clear.
  assign clr = reset | flush;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign occupancy = state_occupancy(state_q);

  // Next-state and register-enable decode for the fill state machine.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    state_d        = state_q;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_en = 1'b1;
        end
      end
      ONE: begin
        unique case ({in_fire, out_fire})
          2'b11: begin
            main_en = 1'b1;           // pass-through: replace the popped entry
          end
          2'b10: begin
            state_d = FULL;
            skid_en = 1'b1;           // main is stalled, park new entry in skid
          end
          2'b01: begin
            state_d = EMPTY;
          end
          default: ;
        endcase
      end
      FULL: begin
        // in_ready is low here, so only the pop side can move.
        if (out_fire) begin
          state_d        = ONE;
          main_en        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;              // illegal encoding recovers to empty
      end
    endcase
  end

  // Fill-state register; reset/flush discard everything, including any
  // handshake that coincides with them.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  // Main register drives out_data directly.
  dffe_sclr #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk (clk),
    .clr (clr),
    .en  (main_en),
    .d   (main_d),
    .q   (out_data)
  );

  // Skid register holds the entry accepted while main was stalled.
  dffe_sclr #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk (clk),
    .clr (clr),
    .en  (skid_en),
    .d   (in_data),
    .q   (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios plus a random
// valid/ready run against a queue scoreboard.
module tb_pipe_skid_stage;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_skid_stage #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic ov, input logic ir,
                              input logic [1:0] occ, input logic [31:0] data);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    check({tag, ".in_ready"},  32'(in_ready),  32'(ir));
    check({tag, ".occupancy"}, 32'(occupancy), 32'(occ));
    check({tag, ".out_data"},  out_data,       data);
  endtask

  logic [31:0] sb[$];
  logic [31:0] held;
  logic        stalled;
  logic        pushed, popped;
  int          budget;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;

    // Reset with upstream pushing: nothing must be captured.
    step(); step();
    expect_state("reset_held", 1'b0, 1'b1, 2'd0, 32'h0);
    reset = 1'b0; in_valid = 1'b0;
    step();
    expect_state("reset_release", 1'b0, 1'b1, 2'd0, 32'h0);

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      step();
      expect_state($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, 32'(i));
    end
    in_valid = 1'b0;
    step();
    check("stream_drain.occupancy", 32'(occupancy), 32'd0);

    // Backpressure fills the skid entry.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h11;
    step();
    expect_state("bp_a", 1'b1, 1'b1, 2'd1, 32'h11);
    in_data = 32'h22;
    step();
    expect_state("bp_full", 1'b1, 1'b0, 2'd2, 32'h11);
    in_data = 32'h99;               // offered while in_ready=0: must be ignored
    step();
    expect_state("bp_hold", 1'b1, 1'b0, 2'd2, 32'h11);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    expect_state("bp_pop1", 1'b1, 1'b1, 2'd1, 32'h22);
    step();
    expect_state("bp_pop2", 1'b0, 1'b1, 2'd0, 32'h22);

    // Flush while FULL with upstream offering 0x55.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h33; step();
    in_data = 32'h44; step();
    expect_state("fl_full", 1'b1, 1'b0, 2'd2, 32'h33);
    flush = 1'b1; in_data = 32'h55;
    step();
    expect_state("fl_after", 1'b0, 1'b1, 2'd0, 32'h0);
    flush = 1'b0; in_valid = 1'b0;
    step();
    expect_state("fl_no55", 1'b0, 1'b1, 2'd0, 32'h0);

    // Flush in ONE with a coincident in_fire and out_fire: both discarded.
    in_valid = 1'b1; in_data = 32'h5A; step();
    flush = 1'b1; in_data = 32'h66; out_ready = 1'b1;
    step();
    expect_state("fl_one", 1'b0, 1'b1, 2'd0, 32'h0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    // Reset and flush together while holding one entry.
    in_valid = 1'b1; in_data = 32'h77; step();
    check("rf_pre.occupancy", 32'(occupancy), 32'd1);
    reset = 1'b1; flush = 1'b1; in_data = 32'h88;
    step();
    expect_state("rf_both", 1'b0, 1'b1, 2'd0, 32'h0);
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step();
    expect_state("rf_after", 1'b0, 1'b1, 2'd0, 32'h0);

    // Random valid/ready against a FIFO scoreboard, with stall stability.
    sb.delete();
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      in_data   = $urandom;
      pushed  = in_valid & in_ready;
      popped  = out_valid & out_ready;
      stalled = out_valid & ~out_ready;
      held    = out_data;
      if (popped) begin
        if (sb.size() == 0) check("rnd_pop_empty", 32'd1, 32'd0);
        else check("rnd_order", out_data, sb.pop_front());
      end
      if (pushed) sb.push_back(in_data);
      step();
      check("rnd_occupancy", 32'(occupancy), 32'(sb.size()));
      if (stalled) begin
        check("rnd_stall_data",  out_data,        held);
        check("rnd_stall_valid", 32'(out_valid), 32'd1);
      end
    end

    // Drain whatever remains, bounded.
    in_valid = 1'b0; out_ready = 1'b1;
    budget = 10;
    while (out_valid && budget > 0) begin
      if (sb.size() == 0) check("drain_extra", 32'd1, 32'd0);
      else check("drain_order", out_data, sb.pop_front());
      step();
      budget--;
    end
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_sb_empty",  32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised elastic pipeline register with valid/ready handshake on both sides, a 2-entry skid buffer, and a synchronous flush.
- Successor to the plain enable/clear pipeline flop.
- Stall is no longer a global enable: it propagates as backpressure via out_ready, with no combinational ready path from output to input.
- Sits between MIPS pipeline stages (IF/ID, ID/EX, ...), one instance per stage boundary carrying the packed stage bundle.

Parameters:
- WIDTH, 32, bit width of the data bundle carried through the stage.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into both data registers on reset and on flush (e.g. a NOP encoding).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of stage contents (branch mispredict / exception).
- in_valid  input  1  upstream has data.
- in_ready  output  1  stage can accept; registered.
- in_data  input  WIDTH  upstream bundle.
- out_valid  output  1  stage holds valid data for downstream.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  bundle to downstream; driven directly from the main register.
- occupancy  output  2  entries held (0, 1 or 2).

Behaviour:
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Transfers occur only on clk rising edge.
- Storage and state:
  - Two registers: main (drives out_data) and skid.
  - States: EMPTY (occupancy 0), ONE (main valid), FULL (main and skid valid).
- Outputs from state:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL).
  - Both are decoded from registered state only.
- Transitions, applied when neither reset nor flush is asserted:
  - EMPTY: in_fire -> ONE, main <= in_data. No in_fire -> stay EMPTY.
  - ONE, in_fire & out_fire -> ONE, main <= in_data.
  - ONE, in_fire only -> FULL, skid <= in_data.
  - ONE, out_fire only -> EMPTY.
  - ONE, neither -> hold.
  - FULL (in_ready=0, no in_fire possible): out_fire -> ONE, main <= skid. Otherwise hold.
- Latency and throughput:
  - 1 cycle from in_fire (EMPTY) to out_valid=1.
  - Sustained throughput 1 transfer/cycle when out_ready is held high.
- Ordering: FIFO; no reordering, duplication or loss except on flush.
- Stability: while out_valid & !out_ready, out_data and out_valid hold unchanged.
- Reset (synchronous, highest priority):
  - state <= EMPTY; main, skid <= RESET_VAL.
  - Outputs after reset edge: out_valid=0, in_ready=1, occupancy=0, out_data=RESET_VAL.
  - Reset asserted mid-transfer discards all contents; any in_fire that cycle is dropped.
- Flush (priority below reset, above handshake):
  - Same effect as reset on state and data.
  - A coincident in_fire or out_fire is discarded. Upstream sees in_ready=1 that cycle, but the data is dropped; downstream must not consume on a flush cycle.
- Simultaneous reset and flush: reset behaviour.
- occupancy: 0/1/2 encoded from state.

Decomposition:
- Package pipe_pkg holds:
  - typedef stage_state_t {EMPTY=2'b00, ONE=2'b01, FULL=2'b10}; encoding 2'b11 is illegal and returns to EMPTY.
  - Shared constant NOP_BUNDLE, used as the RESET_VAL default for instruction-carrying stages.
- One sub-module: dffe_sclr (WIDTH, RESET_VAL).
  - Enable register with synchronous clear; instantiated twice (main, skid).
- Control FSM stays in the top module.

Test Plan:
- Reset: hold reset 2 cycles with in_valid=1, in_data=32'hDEADBEEF -> out_valid=0, in_ready=1, occupancy=0, out_data=0 after release; no data captured.
- Streaming: out_ready=1, push 8'h01..8'h08 on consecutive cycles -> out_data 01..08 one cycle later each, in_ready never deasserts, occupancy stays 1.
- Backpressure:
  - Push A=0x11, then B=0x22 with out_ready=0 -> occupancy=2, in_ready=0, out_data=0x11 held.
  - Raise out_ready -> 0x11 then 0x22 delivered, in_ready returns to 1 one cycle after the first pop.
- Flush while FULL (0x33, 0x44 held) with in_valid=1, in_data=0x55 -> next cycle occupancy=0, out_valid=0, out_data=RESET_VAL; 0x55 never appears.
- Reset and flush together with occupancy=1 -> same as reset.
- Random valid/ready (10k cycles) vs scoreboard -> output sequence equals input sequence, and data is stable under stall.
